// File: rtl/wam_pkg.sv
// Shared constants and helpers for the whack-a-mole display path.
// Used by the score/timer BCD encoder and the digit decoders.
package wam_pkg;

    localparam logic [0:0] ENC_IDLE = 1'b0;
    localparam logic [0:0] ENC_CONV = 1'b1;

    localparam logic [3:0] BCD_ADJ_THRESHOLD = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD       = 4'd3;

    localparam int unsigned BCD_MAX_DIGITS = 16;

    // Callers zero-extend their packed BCD bus to 64 bits before slicing.
    function automatic logic [3:0] bcd_digit(input logic [63:0] packed_bcd,
                                             input int unsigned idx);
        return packed_bcd[4*idx +: 4];
    endfunction

    // True when DIGITS decimal digits can hold every WIDTH-bit unsigned value.
    function automatic bit digits_ok(input int unsigned w, input int unsigned d);
        longint unsigned p;
        longint unsigned maxv;
        p = 1;
        if (w >= 64)
            maxv = '1;
        else
            maxv = (64'd1 << w) - 64'd1;
        for (int unsigned i = 0; i < d; i++) begin
            if (p > maxv)
                return 1'b1;
            p = p * 64'd10;
        end
        return p > maxv;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: d >= 5 becomes d + 3.
// Purely combinational; no carry leaves the digit.
module bcd_digit_adjust
    import wam_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= BCD_ADJ_THRESHOLD)
            adjusted = digit + BCD_ADJ_ADD;
    end

endmodule

// File: rtl/bin_bcd_encoder.sv
// Sequential shift-and-add-3 binary to packed BCD converter, one bit per clock.
// Results and per-digit valid flags update only on completion, with a one-cycle done pulse.
module bin_bcd_encoder
    import wam_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_valid
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned BW = 4 * DIGITS;

    if (!digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
        $error("bin_bcd_encoder: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
    end
    if (DIGITS > BCD_MAX_DIGITS || DIGITS == 0) begin : g_bad_range
        $error("bin_bcd_encoder: DIGITS=%0d outside 1..%0d", DIGITS, BCD_MAX_DIGITS);
    end

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    scratch;
    logic [CW-1:0]    cnt;

    logic [BW-1:0]    adjusted;
    logic [BW-1:0]    scratch_next;
    logic [WIDTH-1:0] shreg_next;
    logic [DIGITS-1:0] dv_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (scratch[4*g +: 4]),
            .adjusted (adjusted[4*g +: 4])
        );
    end

    always_comb begin
        scratch_next = {adjusted[BW-2:0], shreg[WIDTH-1]};
        shreg_next   = shreg << 1;
    end

    // Walk from the top digit down so every digit below the first nonzero one is flagged.
    always_comb begin
        logic        seen;
        int unsigned idx;
        seen    = 1'b0;
        idx     = 0;
        dv_next = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            idx          = DIGITS - 1 - i;
            seen         = seen | (bcd_digit(64'(scratch_next), idx) != 4'd0);
            dv_next[idx] = seen;
        end
        dv_next[0] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ENC_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            bcd         <= '0;
            digit_valid <= DIGITS'(1);
            shreg       <= '0;
            scratch     <= '0;
            cnt         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ENC_IDLE: begin
                    if (start) begin
                        shreg   <= value;
                        scratch <= '0;
                        cnt     <= CW'(WIDTH - 1);
                        busy    <= 1'b1;
                        state   <= ENC_CONV;
                    end
                end
                ENC_CONV: begin
                    scratch <= scratch_next;
                    shreg   <= shreg_next;
                    cnt     <= cnt - CW'(1);
                    if (cnt == '0) begin
                        bcd         <= scratch_next;
                        digit_valid <= dv_next;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ENC_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ENC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_bcd_encoder.sv
// Scoreboard bench for bin_bcd_encoder (WIDTH=8, DIGITS=3): stimulus queues
// expected results and completion cycles, a negedge monitor pops them on done.
module tb_bin_bcd_encoder;
    import wam_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned D = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  value = '0;
    logic          busy;
    logic          done;
    logic [4*D-1:0] bcd;
    logic [D-1:0]  digit_valid;

    bin_bcd_encoder #(.WIDTH(W), .DIGITS(D)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .value       (value),
        .busy        (busy),
        .done        (done),
        .bcd         (bcd),
        .digit_valid (digit_valid)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [11:0] eb;
        logic [2:0]  ed;
        int unsigned at;
        int unsigned v;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin : mon
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check($sformatf("bcd(v=%0d)", e.v), 32'(bcd), 32'(e.eb));
                check($sformatf("digit_valid(v=%0d)", e.v), 32'(digit_valid), 32'(e.ed));
                check($sformatf("done_cycle(v=%0d)", e.v), cyc, e.at);
                for (int unsigned i = 0; i < D; i++)
                    check("digit_le9", 32'(bcd_digit(64'(bcd), i) > 4'd9), 32'd0);
            end
        end
    end

    // Issue one conversion; optionally poke start with 200 during CONV or keep start held.
    task automatic conv(input logic [7:0] v, input logic [11:0] eb, input logic [2:0] ed,
                        input int unsigned inject, input bit hold);
        start = 1'b1;
        value = v;
        @(posedge clock); #1;
        if (!hold) start = 1'b0;
        sb.push_back('{eb: eb, ed: ed, at: cyc + W, v: 32'(v)});
        for (int unsigned i = 1; i <= W; i++) begin
            check("busy_high", 32'(busy), 32'd1);
            if (i == inject) begin
                start = 1'b1;
                value = 8'd200;
            end
            @(posedge clock); #1;
            if (i == inject) begin
                start = 1'b0;
                value = v;
            end
        end
        check("busy_low_at_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] rb;
        logic [2:0]  rd;

        repeat (3) @(posedge clock);
        #1;
        check("in_reset_busy", 32'(busy), 32'd0);
        check("in_reset_done", 32'(done), 32'd0);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        check("reset_bcd", 32'(bcd), 32'h000);
        check("reset_dv", 32'(digit_valid), 32'b001);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        conv(8'd255, 12'h255, 3'b111, 0, 1'b0);
        conv(8'd0,   12'h000, 3'b001, 0, 1'b0);
        conv(8'd9,   12'h009, 3'b001, 0, 1'b0);
        conv(8'd10,  12'h010, 3'b011, 0, 1'b0);
        conv(8'd100, 12'h100, 3'b111, 0, 1'b0);
        conv(8'd42,  12'h042, 3'b011, 3, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        check("after_ignored_start_busy", 32'(busy), 32'd0);

        start = 1'b1;
        value = 8'd123;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("midconv_reset_busy", 32'(busy), 32'd0);
        check("midconv_reset_done", 32'(done), 32'd0);
        check("midconv_reset_bcd", 32'(bcd), 32'h000);
        check("midconv_reset_dv", 32'(digit_valid), 32'b001);
        @(negedge clock) reset = 1'b1;
        repeat (W + 3) @(posedge clock);
        #1;
        check("post_reset_bcd", 32'(bcd), 32'h000);
        check("post_reset_busy", 32'(busy), 32'd0);

        conv(8'd17, 12'h017, 3'b011, 0, 1'b1);
        conv(8'd99, 12'h099, 3'b011, 0, 1'b0);

        for (int unsigned v = 0; v < 256; v++) begin
            rb = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            rd = (v >= 100) ? 3'b111 : (v >= 10) ? 3'b011 : 3'b001;
            conv(8'(v), rb, rd, 0, 1'b0);
        end

        repeat (W + 4) @(posedge clock);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
